// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Contents:
//    state_e       FSM state encoding (also visible on the debug state port)
//    Op*/Funct*    opcode and R-type function field constants
//    alusrcb_e     ALU B-operand select encoding
//    pcsrc_e       next-PC select encoding
//    alucontrol_e  ALU operation encoding
//    aluop_e       coarse ALU request from the FSM to the ALU decoder
//    ctrl_t        per-state control word, state_ctrl() maps a state to it
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecute = 4'd6,
      StAluWb   = 4'd7,
      StBranch  = 4'd8,
      StAddiEx  = 4'd9,
      StAddiWb  = 4'd10,
      StJump    = 4'd11
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;

   localparam logic [5:0] FunctAdd = 6'b100000;
   localparam logic [5:0] FunctSub = 6'b100010;
   localparam logic [5:0] FunctAnd = 6'b100100;
   localparam logic [5:0] FunctOr  = 6'b100101;
   localparam logic [5:0] FunctSlt = 6'b101010;

   typedef enum logic [1:0] {
      SrcBReg   = 2'b00,
      SrcBFour  = 2'b01,
      SrcBImm   = 2'b10,
      SrcBImmSh = 2'b11
   } alusrcb_e;

   typedef enum logic [1:0] {
      PcSrcAlu    = 2'b00,
      PcSrcAluOut = 2'b01,
      PcSrcJump   = 2'b10
   } pcsrc_e;

   typedef enum logic [2:0] {
      AluAnd = 3'b000,
      AluOr  = 3'b001,
      AluAdd = 3'b010,
      AluSub = 3'b110,
      AluSlt = 3'b111
   } alucontrol_e;

   typedef enum logic [1:0] {
      AluOpAdd   = 2'b00,
      AluOpSub   = 2'b01,
      AluOpFunct = 2'b10
   } aluop_e;

   typedef struct packed {
      logic     pcwrite;
      logic     branch;
      logic     memwrite;
      logic     irwrite;
      logic     regwrite;
      logic     alusrca;
      logic     iord;
      logic     memtoreg;
      logic     regdst;
      alusrcb_e alusrcb;
      pcsrc_e   pcsrc;
      aluop_e   aluop;
   } ctrl_t;

   // Moore decode: every field here depends on the state alone.
   function automatic ctrl_t state_ctrl(state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         StFetch: begin
            c.alusrcb = SrcBFour;
            c.irwrite = 1'b1;
            c.pcwrite = 1'b1;
         end
         StDecode: begin
            // Speculative branch target: PC+4 + (imm << 2).
            c.alusrcb = SrcBImmSh;
         end
         StMemAdr: begin
            c.alusrca = 1'b1;
            c.alusrcb = SrcBImm;
         end
         StMemRd: begin
            c.iord = 1'b1;
         end
         StMemWb: begin
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
         end
         StMemWr: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         StExecute: begin
            c.alusrca = 1'b1;
            c.alusrcb = SrcBReg;
            c.aluop   = AluOpFunct;
         end
         StAluWb: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
         end
         StBranch: begin
            c.alusrca = 1'b1;
            c.alusrcb = SrcBReg;
            c.aluop   = AluOpSub;
            c.pcsrc   = PcSrcAluOut;
            c.branch  = 1'b1;
         end
         StAddiEx: begin
            c.alusrca = 1'b1;
            c.alusrcb = SrcBImm;
         end
         StAddiWb: begin
            c.regwrite = 1'b1;
         end
         StJump: begin
            c.pcsrc   = PcSrcJump;
            c.pcwrite = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// master: controller side (receives op/funct/zero, drives all controls).
// slave:  datapath side (drives op/funct/zero, receives all controls).
// Signals:
//    op, funct   instruction register fields
//    zero        ALU zero flag
//    pcen        PC register enable
//    memwrite    memory write strobe
//    irwrite     instruction register load
//    regwrite    register file write enable
//    alusrca     ALU A select (0 PC, 1 reg A)
//    iord        memory address select (0 PC, 1 ALUOut)
//    memtoreg    write-back select (0 ALUOut, 1 memory data)
//    regdst      destination select (0 rt, 1 rd)
//    alusrcb     ALU B select
//    pcsrc       next-PC select
//    alucontrol  ALU operation
//    illegal     unsupported opcode/funct pulse
//    state       current FSM state for debug
interface multicycle_control_if;

   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       alusrca;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  op, funct, zero,
      output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
      output alusrcb, pcsrc, alucontrol, illegal, state
   );

   modport slave (
      output op, funct, zero,
      input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
      input  alusrcb, pcsrc, alucontrol, illegal, state
   );

endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: turns the FSM's coarse ALU request plus the R-type funct field
// into an ALU operation.
// Ports:
//    aluop       in   coarse request (add, sub, or decode funct)
//    funct       in   R-type function field
//    alucontrol  out  ALU operation
//    bad_funct   out  funct not supported while aluop requests funct decode
module mc_aludec
   import multicycle_control_pkg::*;
(
   input  aluop_e      aluop,
   input  logic [5:0]  funct,
   output alucontrol_e alucontrol,
   output logic        bad_funct
);

   always_comb begin
      alucontrol = AluAdd;
      bad_funct  = 1'b0;
      case (aluop)
         AluOpAdd: alucontrol = AluAdd;
         AluOpSub: alucontrol = AluSub;
         AluOpFunct: begin
            case (funct)
               FunctAdd: alucontrol = AluAdd;
               FunctSub: alucontrol = AluSub;
               FunctAnd: alucontrol = AluAnd;
               FunctOr:  alucontrol = AluOr;
               FunctSlt: alucontrol = AluSlt;
               default: begin
                  // Unknown funct still drives a harmless add.
                  alucontrol = AluAdd;
                  bad_funct  = 1'b1;
               end
            endcase
         end
         default: alucontrol = AluAdd;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: Moore FSM sequencing fetch, decode, memory,
// R-type, branch, addi and jump instructions.
// Parameters:
//    JUMP_EN  1 enables the j instruction; 0 makes it illegal
// Ports:
//    clk      clock, all state changes on the rising edge
//    reset    synchronous active-high reset
//    bus      multicycle_control_if.master control bundle
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter bit JUMP_EN = 1'b1
) (
   input logic                  clk,
   input logic                  reset,
   multicycle_control_if.master bus
);

   state_e      state_q, state_d;
   ctrl_t       ctrl_q;
   ctrl_t       ctrl;
   logic        op_bad;
   logic        funct_bad;
   alucontrol_e alu_ctl;

   mc_aludec u_aludec (
      .aluop      (ctrl.aluop),
      .funct      (bus.funct),
      .alucontrol (alu_ctl),
      .bad_funct  (funct_bad)
   );

   // Next-state logic; op is only decoded in DECODE (and MEMADR to pick the
   // load or store path), funct only in EXECUTE via the ALU decoder.
   always_comb begin
      state_d = StFetch;
      op_bad  = 1'b0;
      case (state_q)
         StFetch: state_d = StDecode;
         StDecode: begin
            case (bus.op)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype:    state_d = StExecute;
               OpBeq:      state_d = StBranch;
               OpAddi:     state_d = StAddiEx;
               OpJ: begin
                  if (JUMP_EN) begin
                     state_d = StJump;
                  end else begin
                     op_bad = 1'b1;
                  end
               end
               default: op_bad = 1'b1;
            endcase
         end
         StMemAdr: begin
            if (bus.op == OpSw) begin
               state_d = StMemWr;
            end else if (bus.op == OpLw) begin
               state_d = StMemRd;
            end else begin
               state_d = StFetch;
            end
         end
         StMemRd:   state_d = StMemWb;
         StExecute: state_d = funct_bad ? StFetch : StAluWb;
         StAddiEx:  state_d = StAddiWb;
         default:   state_d = StFetch;
      endcase
   end

   // The control word is registered alongside the state, computed from the
   // state being entered, so the outputs come straight from flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
         ctrl_q  <= state_ctrl(StFetch);
      end else begin
         state_q <= state_d;
         ctrl_q  <= state_ctrl(state_d);
      end
   end

   // While reset is held the selects show FETCH but nothing may write,
   // even in the cycle reset arrives mid-instruction.
   always_comb begin
      ctrl = ctrl_q;
      if (reset) begin
         ctrl          = state_ctrl(StFetch);
         ctrl.pcwrite  = 1'b0;
         ctrl.branch   = 1'b0;
         ctrl.irwrite  = 1'b0;
         ctrl.memwrite = 1'b0;
         ctrl.regwrite = 1'b0;
      end
   end

   assign bus.pcen       = ctrl.pcwrite | (ctrl.branch & bus.zero);
   assign bus.memwrite   = ctrl.memwrite;
   assign bus.irwrite    = ctrl.irwrite;
   assign bus.regwrite   = ctrl.regwrite;
   assign bus.alusrca    = ctrl.alusrca;
   assign bus.iord       = ctrl.iord;
   assign bus.memtoreg   = ctrl.memtoreg;
   assign bus.regdst     = ctrl.regdst;
   assign bus.alusrcb    = ctrl.alusrcb;
   assign bus.pcsrc      = ctrl.pcsrc;
   assign bus.alucontrol = alu_ctl;
   assign bus.illegal    = ~reset & (op_bad | funct_bad);
   assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: randomized instruction streams
// compared against an instruction-level reference model.
module tb_multicycle_control;

   typedef int iq_t[$];

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   multicycle_control_if bus ();
   multicycle_control_if bus0 ();

   multicycle_control #(.JUMP_EN(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   multicycle_control #(.JUMP_EN(1'b0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int mw_count = 0;
   int mw_cycle = 0;
   int rw_count = 0;

   // ---------------- reference model ----------------
   function automatic bit op_legal(logic [5:0] op, bit jen);
      return op == 6'h23 || op == 6'h2b || op == 6'h00 || op == 6'h04 || op == 6'h08 ||
             (jen && op == 6'h02);
   endfunction

   function automatic int funct_alu(logic [5:0] f);
      case (f)
         6'h20:   return 2;
         6'h22:   return 6;
         6'h24:   return 0;
         6'h25:   return 1;
         6'h2a:   return 7;
         default: return -1;
      endcase
   endfunction

   // State visited in each cycle of one instruction, FETCH first.
   function automatic iq_t inst_seq(logic [5:0] op, logic [5:0] funct, bit jen);
      iq_t s;
      s.push_back(0);
      s.push_back(1);
      if (op_legal(op, jen)) begin
         case (op)
            6'h23: begin s.push_back(2); s.push_back(3); s.push_back(4); end
            6'h2b: begin s.push_back(2); s.push_back(5); end
            6'h00: begin
               s.push_back(6);
               if (funct_alu(funct) >= 0) s.push_back(7);
            end
            6'h04: s.push_back(8);
            6'h08: begin s.push_back(9); s.push_back(10); end
            default: s.push_back(11);
         endcase
      end
      return s;
   endfunction

   // {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
   //  alusrcb[1:0], pcsrc[1:0], alucontrol[2:0], illegal}
   function automatic logic [15:0] exp_out(int st, logic [5:0] op, logic [5:0] funct,
                                           logic zero, bit jen, bit in_reset);
      logic pcw, br, mw, irw, rw, asa, iord, m2r, rdst, ill;
      logic [1:0] srcb, pcs;
      logic [2:0] alu;
      int fa;
      pcw = 0; br = 0; mw = 0; irw = 0; rw = 0; asa = 0; iord = 0; m2r = 0; rdst = 0;
      ill = 0; srcb = 2'b00; pcs = 2'b00; alu = 3'b010;
      case (st)
         0: begin srcb = 2'b01; irw = 1; pcw = 1; end
         1: begin srcb = 2'b11; ill = !op_legal(op, jen); end
         2: begin asa = 1; srcb = 2'b10; end
         3: iord = 1;
         4: begin m2r = 1; rw = 1; end
         5: begin iord = 1; mw = 1; end
         6: begin
            asa = 1;
            fa = funct_alu(funct);
            if (fa < 0) ill = 1;
            else alu = 3'(fa);
         end
         7: begin rdst = 1; rw = 1; end
         8: begin asa = 1; alu = 3'b110; pcs = 2'b01; br = 1; end
         9: begin asa = 1; srcb = 2'b10; end
         10: rw = 1;
         11: begin pcs = 2'b10; pcw = 1; end
         default: ;
      endcase
      if (in_reset) begin
         pcw = 0; br = 0; irw = 0; mw = 0; rw = 0; ill = 0;
      end
      return {pcw | (br & zero), mw, irw, rw, asa, iord, m2r, rdst, srcb, pcs, alu, ill};
   endfunction

   function automatic logic [15:0] pack_main();
      return {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.alusrca, bus.iord,
              bus.memtoreg, bus.regdst, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal};
   endfunction

   function automatic logic [15:0] pack_j0();
      return {bus0.pcen, bus0.memwrite, bus0.irwrite, bus0.regwrite, bus0.alusrca,
              bus0.iord, bus0.memtoreg, bus0.regdst, bus0.alusrcb, bus0.pcsrc,
              bus0.alucontrol, bus0.illegal};
   endfunction

   task automatic drive(logic [5:0] op, logic [5:0] funct, logic zero);
      bus.op = op; bus.funct = funct; bus.zero = zero;
      bus0.op = op; bus0.funct = funct; bus0.zero = zero;
   endtask

   // Holds reset for a few edges, checks both DUTs, returns at posedge+1 in
   // the first FETCH after release.
   task automatic do_reset();
      logic [15:0] e;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      e = exp_out(0, bus.op, bus.funct, bus.zero, 1'b1, 1'b1);
      checks++;
      if (bus.state !== 4'd0 || pack_main() !== e) begin
         errors++;
         $display("FAIL reset_main state %0d outs %h want state 0 outs %h",
                  bus.state, pack_main(), e);
      end
      checks++;
      if (bus0.state !== 4'd0 || pack_j0() !== e) begin
         errors++;
         $display("FAIL reset_nojump state %0d outs %h want state 0 outs %h",
                  bus0.state, pack_j0(), e);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Runs one instruction (or its first ncyc cycles) on the main DUT.
   // zmode: -1 random zero per cycle, else the fixed zero value.
   task automatic run_inst(logic [5:0] op, logic [5:0] funct, int zmode, int ncyc,
                           string name);
      iq_t seq;
      int n;
      seq = inst_seq(op, funct, 1'b1);
      n = (ncyc > 0 && ncyc < seq.size()) ? ncyc : seq.size();
      for (int k = 0; k < n; k++) begin
         logic z;
         logic [15:0] e;
         z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         drive(op, funct, z);
         @(negedge clk);
         cyc++;
         checks++;
         if (bus.state !== 4'(seq[k])) begin
            errors++;
            $display("FAIL %s state step %0d got %0d want %0d", name, k, bus.state, seq[k]);
         end
         e = exp_out(seq[k], op, funct, z, 1'b1, 1'b0);
         checks++;
         if (pack_main() !== e) begin
            errors++;
            $display("FAIL %s outputs step %0d got %h want %h", name, k, pack_main(), e);
         end
         checks++;
         if ($countones({bus.memwrite, bus.regwrite, bus.irwrite}) > 1) begin
            errors++;
            $display("FAIL %s strobes step %0d got mw%b rw%b ir%b want at most one", name, k,
                     bus.memwrite, bus.regwrite, bus.irwrite);
         end
         if (bus.memwrite === 1'b1) begin mw_count++; mw_cycle = cyc; end
         if (bus.regwrite === 1'b1) rw_count++;
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      drive(6'h00, 6'h20, 1'b0);
      do_reset();
      run_inst(6'h23, 6'h00, -1, 0, "first_after_reset");
   endtask

   task automatic test_program();
      do_reset();
      cyc = 0; mw_count = 0; mw_cycle = 0;
      run_inst(6'h08, 6'h00, -1, 0, "prog_addi2");
      run_inst(6'h08, 6'h00, -1, 0, "prog_addi3");
      run_inst(6'h00, 6'h22, -1, 0, "prog_sub");
      run_inst(6'h2b, 6'h00, -1, 0, "prog_sw");
      checks++;
      if (mw_count !== 1) begin
         errors++;
         $display("FAIL prog_memwrite_count got %0d want 1", mw_count);
      end
      checks++;
      if (mw_cycle !== 16) begin
         errors++;
         $display("FAIL prog_memwrite_cycle got %0d want 16", mw_cycle);
      end
   endtask

   task automatic test_lw();
      rw_count = 0;
      run_inst(6'h23, 6'h00, -1, 0, "lw");
      checks++;
      if (rw_count !== 1) begin
         errors++;
         $display("FAIL lw_regwrite_count got %0d want 1", rw_count);
      end
   endtask

   task automatic test_beq();
      run_inst(6'h04, 6'h00, 1, 0, "beq_taken");
      run_inst(6'h04, 6'h00, 0, 0, "beq_not_taken");
      run_inst(6'h08, 6'h00, 1, 0, "after_beq");
   endtask

   task automatic test_illegal();
      rw_count = 0; mw_count = 0;
      run_inst(6'h3f, 6'h00, -1, 0, "illegal_op");
      run_inst(6'h00, 6'h07, -1, 0, "illegal_funct");
      run_inst(6'h00, 6'h2a, -1, 0, "slt_after_illegal");
      checks++;
      if (rw_count !== 1 || mw_count !== 0) begin
         errors++;
         $display("FAIL illegal_writes got rw %0d mw %0d want rw 1 mw 0", rw_count, mw_count);
      end
   endtask

   task automatic test_reset_mid();
      logic [5:0] ops[3] = '{6'h2b, 6'h23, 6'h00};
      int tgt[3] = '{5, 3, 7};
      for (int i = 0; i < 3; i++) begin
         logic [15:0] e;
         do_reset();
         run_inst(ops[i], 6'h24, -1, 3, "pre_reset");
         reset = 1'b1;
         @(negedge clk);
         e = exp_out(0, ops[i], 6'h24, bus.zero, 1'b1, 1'b1);
         checks++;
         if (bus.state !== 4'(tgt[i]) || bus.memwrite !== 1'b0 || bus.regwrite !== 1'b0 ||
             pack_main() !== e) begin
            errors++;
            $display("FAIL mid_reset_%0d state %0d outs %h want state %0d outs %h", tgt[i],
                     bus.state, pack_main(), tgt[i], e);
         end
         @(posedge clk);
         #1;
         checks++;
         if (bus.state !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_%0d_next got %0d want 0", tgt[i], bus.state);
         end
         reset = 1'b0;
         @(negedge clk);
         e = exp_out(0, ops[i], 6'h24, bus.zero, 1'b1, 1'b0);
         checks++;
         if (bus.state !== 4'd0 || pack_main() !== e) begin
            errors++;
            $display("FAIL mid_reset_%0d_release state %0d outs %h want 0 %h", tgt[i],
                     bus.state, pack_main(), e);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_jump();
      do_reset();
      run_inst(6'h02, 6'h00, -1, 0, "jump_en");
      do_reset();
      // Main DUT walks 0,1,11,0; the JUMP_EN=0 copy walks 0,1,0,1.
      begin
         int want[4] = '{0, 1, 0, 1};
         for (int k = 0; k < 4; k++) begin
            logic [15:0] e;
            logic z;
            z = 1'($urandom_range(0, 1));
            drive(6'h02, 6'h00, z);
            @(negedge clk);
            e = exp_out(want[k], 6'h02, 6'h00, z, 1'b0, 1'b0);
            checks++;
            if (bus0.state !== 4'(want[k]) || pack_j0() !== e) begin
               errors++;
               $display("FAIL jump_disabled step %0d state %0d outs %h want %0d %h", k,
                        bus0.state, pack_j0(), want[k], e);
            end
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] pool[6] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02};
      logic [5:0] fpool[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
      do_reset();
      for (int i = 0; i < 60; i++) begin
         logic [5:0] op, funct;
         op = (($urandom % 8) == 0) ? 6'($urandom) : pool[$urandom % 6];
         funct = (($urandom % 6) == 0) ? 6'($urandom) : fpool[$urandom % 5];
         run_inst(op, funct, -1, 0, "random");
      end
   endtask

   initial begin
      drive(6'h00, 6'h00, 1'b0);
      test_reset();
      test_program();
      test_lw();
      test_beq();
      test_illegal();
      test_reset_mid();
      test_jump();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
